apb_cmd_master: RTL

- APB requester that sits directly upstream of the team's APB memory slave.
- Accepts single read/write commands on a valid/ready command port and drives the full APB SETUP/ACCESS sequence.
- Waits for pready, then returns read data and error status on a valid/ready response port.
- Includes an access-phase watchdog so a hung slave cannot stall the command source.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_watchdog.sv | 33 +++
 rtl/apb_cmd_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester types: FSM states, default bus widths and the command bundle.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_W-1:0]   addr;
    logic [APB_DATA_W-1:0]   wdata;
    logic [APB_DATA_W/8-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_watchdog.sv
// Access-phase watchdog: load sets TIMEOUT_CYCLES-1, dec counts down to zero, expired flags zero.
// Registered count, expiry visible the cycle the count reaches zero; no flow control.
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic load,
  input  logic clr,
  input  logic dec,
  output logic expired
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: one command per SETUP/ACCESS transfer, watchdog abort, response held until rsp_ready.
// Accept-to-rsp_valid 3 cycles with a zero-wait slave; cmd_ready stays low until the response handshake.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  apb_mst_state_e      state_q, state_d;
  logic                psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [DATA_W/8-1:0] pstrb_d;
  logic                rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                wd_load, wd_clr, wd_dec, wd_expired;

  assign cmd_ready = (state_q == IDLE) && !preset;

  apb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .pclk    (pclk),
    .preset  (preset),
    .load    (wd_load),
    .clr     (wd_clr),
    .dec     (wd_dec),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    pstrb_d     = pstrb;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    wd_load     = 1'b0;
    wd_clr      = 1'b0;
    wd_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // Reads drive zero data and strobes so the slave never sees stale write payload.
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wd_load   = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over an expiring watchdog on the same edge.
        if (pready) begin
          rsp_rdata_d = pwrite ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          wd_clr      = 1'b1;
          state_d     = RESP;
        end else if (wd_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          wd_clr      = 1'b1;
          state_d     = RESP;
        end else begin
          wd_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pstrb     <= pstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
